// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter_pkg
//  Description : Shared definitions for the register-file write arbiter:
//                bank geometry defaults, output-stage FSM encoding and
//                requester identifiers used by the round-robin pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_write_arbiter_pkg;

    // Bank geometry defaults
    localparam int W    = 32;              // register data width
    localparam int NREG = 16;              // registers in the bank
    localparam int AW   = $clog2(NREG);    // register index width

    // Output-stage FSM: IDLE = nothing staged, WRITE = a grant is staged
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Requester identifiers; also the encoding of the priority pointer
    localparam logic REQ_A = 1'b0;         // ALU writeback
    localparam logic REQ_B = 1'b1;         // memory load

endpackage : reg_write_arbiter_pkg
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-requester round-robin arbiter with a datapath freeze.
//                Grants are combinational from the valids, stall and the
//                1-bit priority pointer; the pointer advances to the
//                requester not just served whenever a grant is issued.
//  Ports       : clk      - clock, rising edge
//                clr      - asynchronous active-low reset
//                valid_a  - requester A has a write pending
//                valid_b  - requester B has a write pending
//                stall    - freeze, suppresses both grants
//                grant_a  - A accepted this cycle
//                grant_b  - B accepted this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic clk,
    input  logic clr,
    input  logic valid_a,
    input  logic valid_b,
    input  logic stall,
    output logic grant_a,
    output logic grant_b
);

    import reg_write_arbiter_pkg::*;

    logic r_prio;       // REQ_A: A wins a tie, REQ_B: B wins a tie
    logic w_enable;     // arbitration allowed this cycle
    logic w_grant_a;
    logic w_grant_b;

    // clr is folded into the enable so no requester sees ready while the
    // block is held in reset.
    assign w_enable  = clr & ~stall;

    // A wins when alone or when the pointer favours it; B symmetrically.
    // The two terms are mutually exclusive by construction.
    assign w_grant_a = w_enable & valid_a & (~valid_b | (r_prio == REQ_A));
    assign w_grant_b = w_enable & valid_b & (~valid_a | (r_prio == REQ_B));

    assign grant_a   = w_grant_a;
    assign grant_b   = w_grant_b;

    // Pointer moves only on a transfer, always away from the winner.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_prio <= REQ_A;
        end else if (w_grant_a) begin
            r_prio <= REQ_B;
        end else if (w_grant_b) begin
            r_prio <= REQ_A;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Arbitrates two register-file write requesters (ALU
//                writeback A, memory load B) onto a single write port.
//                An accepted request is staged for one cycle, during which
//                a one-hot load enable and the write data are presented to
//                the register bank, which captures them on the next edge.
//                Sustains one write per cycle.
//  Ports       : clk              - clock, rising edge
//                clr              - asynchronous active-low reset
//                a_valid/addr/data- requester A write request
//                a_ready          - A accepted this cycle
//                b_valid/addr/data- requester B write request
//                b_ready          - B accepted this cycle
//                stall            - datapath freeze, blocks acceptance
//                ld               - one-hot register load enables
//                wdata            - shared write-data bus
//                busy             - a staged write is being presented
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter  int W    = reg_write_arbiter_pkg::W,
    parameter  int NREG = reg_write_arbiter_pkg::NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_addr,
    input  logic [W-1:0]    a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_addr,
    input  logic [W-1:0]    b_data,
    output logic            b_ready,
    input  logic            stall,
    output logic [NREG-1:0] ld,
    output logic [W-1:0]    wdata,
    output logic            busy
);

    import reg_write_arbiter_pkg::*;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic w_grant_a;
    logic w_grant_b;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .clr     (clr),
        .valid_a (a_valid),
        .valid_b (b_valid),
        .stall   (stall),
        .grant_a (w_grant_a),
        .grant_b (w_grant_b)
    );

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;

    // ------------------------------------------------------------------
    // Winner selection and address decode
    // ------------------------------------------------------------------
    logic            w_xfer;
    logic [AW-1:0]   w_sel_addr;
    logic [W-1:0]    w_sel_data;
    logic [NREG-1:0] w_ld_next;

    assign w_xfer     = w_grant_a | w_grant_b;
    assign w_sel_addr = w_grant_b ? b_addr : a_addr;
    assign w_sel_data = w_grant_b ? b_data : a_data;

    // One-hot decode; an index beyond NREG-1 (non power-of-two bank)
    // decodes to no load at all rather than aliasing.
    always_comb begin
        w_ld_next = '0;
        for (int i = 0; i < NREG; i++) begin
            w_ld_next[i] = (w_sel_addr == AW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Output stage FSM with registered outputs
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [NREG-1:0] r_ld;
    logic [W-1:0]    r_wdata;
    logic            r_busy;

    // A new transfer is staged from either state, so back-to-back writes
    // stay in WRITE without a bubble. wdata is only loaded on a transfer
    // and otherwise keeps its last value.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
            r_ld    <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_state <= WRITE;
                        r_ld    <= w_ld_next;
                        r_wdata <= w_sel_data;
                        r_busy  <= 1'b1;
                    end else begin
                        r_ld    <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (w_xfer) begin
                        r_state <= WRITE;
                        r_ld    <= w_ld_next;
                        r_wdata <= w_sel_data;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_ld    <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ld    <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ld    = r_ld;
    assign wdata = r_wdata;
    assign busy  = r_busy;

endmodule : reg_write_arbiter
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_arbiter
//  Description : Directed self-checking bench for reg_write_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    logic        clk;
    logic        clr;
    logic        a_valid;
    logic [3:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [3:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        stall;
    logic [15:0] ld;
    logic [31:0] wdata;
    logic        busy;

    int checks;
    int failures;

    reg_write_arbiter dut (
        .clk     (clk),
        .clr     (clr),
        .a_valid (a_valid),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .b_ready (b_ready),
        .stall   (stall),
        .ld      (ld),
        .wdata   (wdata),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        stall   = 1'b0;
    endtask

    // Short reset pulse between edges; leaves prio=0 and the FSM idle.
    task automatic do_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        clr = 1'b0;
        #2;
        clr = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        idle_inputs();
        #1;
        clr = 1'b0;
        a_valid = 1'b1; a_addr = 4'd3; a_data = 32'h0000_00A0;
        #1;
        checks++; if (ld !== 16'h0000) begin failures++; $display("FAIL reset_ld: got %h expected %h", ld, 16'h0000); end
        checks++; if (wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata: got %h expected %h", wdata, 32'h0); end
        checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL reset_a_ready: got %b expected 0", a_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++; if (ld !== 16'h0000) begin failures++; $display("FAIL reset_ld_edge: got %h expected %h", ld, 16'h0000); end
        clr = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL post_reset_a_ready: got %b expected 1", a_ready); end
        @(posedge clk); #1;
        checks++; if (ld !== 16'h0008) begin failures++; $display("FAIL post_reset_ld: got %h expected %h", ld, 16'h0008); end
        checks++; if (wdata !== 32'h0000_00A0) begin failures++; $display("FAIL post_reset_wdata: got %h expected %h", wdata, 32'h0000_00A0); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL post_reset_busy: got %b expected 1", busy); end
        a_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (ld !== 16'h0000) begin failures++; $display("FAIL idle_ld: got %h expected %h", ld, 16'h0000); end
        checks++; if (wdata !== 32'h0000_00A0) begin failures++; $display("FAIL idle_wdata_hold: got %h expected %h", wdata, 32'h0000_00A0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_contention();
        logic exp_a;
        do_reset();
        a_valid = 1'b1; a_addr = 4'd1; a_data = 32'd1;
        b_valid = 1'b1; b_addr = 4'd2; b_data = 32'd2;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            checks++; if (a_ready !== exp_a || b_ready !== ~exp_a) begin failures++; $display("FAIL cont_ready[%0d]: got a=%b b=%b expected a=%b b=%b", i, a_ready, b_ready, exp_a, ~exp_a); end
            @(posedge clk); #1;
            checks++; if (ld !== (exp_a ? 16'h0002 : 16'h0004)) begin failures++; $display("FAIL cont_ld[%0d]: got %h expected %h", i, ld, (exp_a ? 16'h0002 : 16'h0004)); end
            checks++; if (wdata !== (exp_a ? 32'd1 : 32'd2)) begin failures++; $display("FAIL cont_wdata[%0d]: got %h expected %h", i, wdata, (exp_a ? 32'd1 : 32'd2)); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cont_busy[%0d]: got %b expected 1", i, busy); end
        end
        idle_inputs();
    endtask

    task automatic test_same_addr();
        do_reset();
        a_valid = 1'b1; a_addr = 4'd5; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 4'd5; b_data = 32'h22;
        @(posedge clk); #1;
        checks++; if (ld !== 16'h0020 || wdata !== 32'h11) begin failures++; $display("FAIL same_first: got ld=%h wdata=%h expected ld=0020 wdata=00000011", ld, wdata); end
        a_valid = 1'b0;
        #1;
        checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL same_b_ready: got %b expected 1", b_ready); end
        @(posedge clk); #1;
        checks++; if (ld !== 16'h0020 || wdata !== 32'h22) begin failures++; $display("FAIL same_second: got ld=%h wdata=%h expected ld=0020 wdata=00000022", ld, wdata); end
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        a_valid = 1'b1; a_addr = 4'd7; a_data = 32'h77;
        @(posedge clk); #1;
        stall = 1'b1;
        b_valid = 1'b1; b_addr = 4'd9; b_data = 32'h99;
        #1;
        checks++; if (ld !== 16'h0080 || busy !== 1'b1) begin failures++; $display("FAIL stall_pending_write: got ld=%h busy=%b expected ld=0080 busy=1", ld, busy); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d]: got a=%b b=%b expected a=0 b=0", i, a_ready, b_ready); end
            @(posedge clk); #1;
            checks++; if (ld !== 16'h0000 || busy !== 1'b0) begin failures++; $display("FAIL stall_ld[%0d]: got ld=%h busy=%b expected ld=0000 busy=0", i, ld, busy); end
        end
        // A was served before the stall, so B must win once it clears.
        stall = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin failures++; $display("FAIL unstall_ready: got a=%b b=%b expected a=0 b=1", a_ready, b_ready); end
        @(posedge clk); #1;
        checks++; if (ld !== 16'h0200 || wdata !== 32'h99) begin failures++; $display("FAIL unstall_ld: got ld=%h wdata=%h expected ld=0200 wdata=00000099", ld, wdata); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        a_valid = 1'b1; a_addr = 4'd4; a_data = 32'h44;
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        checks++; if (ld !== 16'h0000 || wdata !== 32'h0 || busy !== 1'b0) begin failures++; $display("FAIL async_clear: got ld=%h wdata=%h busy=%b expected 0000/0/0", ld, wdata, busy); end
        checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL async_a_ready: got %b expected 0", a_ready); end
        @(posedge clk); #1;
        checks++; if (ld !== 16'h0000) begin failures++; $display("FAIL async_no_pulse: got %h expected 0000", ld); end
        // prio must be back at A despite the aborted A grant.
        clr = 1'b1;
        b_valid = 1'b1; b_addr = 4'd6; b_data = 32'h66;
        #1;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL async_prio: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
        @(posedge clk); #1;
        checks++; if (ld !== 16'h0010 || wdata !== 32'h44) begin failures++; $display("FAIL async_resume: got ld=%h wdata=%h expected ld=0010 wdata=00000044", ld, wdata); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  addrs [4];
        logic [31:0] datas [4];
        logic [15:0] exp_ld [4];
        addrs  = '{4'd0, 4'd15, 4'd8, 4'd3};
        datas  = '{32'hDEAD_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0001};
        exp_ld = '{16'h0001, 16'h8000, 16'h0100, 16'h0008};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_addr = addrs[i]; a_data = datas[i];
            @(posedge clk); #1;
            checks++; if (ld !== exp_ld[i] || wdata !== datas[i] || busy !== 1'b1) begin failures++; $display("FAIL b2b[%0d]: got ld=%h wdata=%h busy=%b expected ld=%h wdata=%h busy=1", i, ld, wdata, busy, exp_ld[i], datas[i]); end
        end
        idle_inputs();
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || ld !== 16'h0000) begin failures++; $display("FAIL b2b_drain: got ld=%h busy=%b expected ld=0000 busy=0", ld, busy); end
    endtask

    task automatic test_single_b();
        do_reset();
        b_valid = 1'b1; b_addr = 4'd15; b_data = 32'hB0B0_B0B0;
        #1;
        checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin failures++; $display("FAIL single_b_ready: got a=%b b=%b expected a=0 b=1", a_ready, b_ready); end
        @(posedge clk); #1;
        checks++; if (ld !== 16'h8000 || wdata !== 32'hB0B0_B0B0) begin failures++; $display("FAIL single_b_ld: got ld=%h wdata=%h expected ld=8000 wdata=b0b0b0b0", ld, wdata); end
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_contention();
        test_same_addr();
        test_stall();
        test_async_reset();
        test_back_to_back();
        test_single_b();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_write_arbiter
`default_nettype wire
